// File: rtl/acc_pkg.sv
// Shared op codes, shift-sequencer state encoding and a decode helper
// for the accumulator register.
package acc_pkg;

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_LOAD = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR = 3'd5;
  localparam logic [2:0] OP_SHL = 3'd6;
  localparam logic [2:0] OP_SHR = 3'd7;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } shift_state_e;

  function automatic logic is_shift(input logic [2:0] op);
    return (op == OP_SHL) || (op == OP_SHR);
  endfunction

endpackage

// File: rtl/acc_reg_if.sv
// Operand/result bundle between the operand bus and the accumulator.
interface acc_reg_if #(
  parameter int WIDTH = 8
);
  localparam int AW = $clog2(WIDTH);

  // start is sampled only while busy=0; a request accepted at an edge
  // yields exactly one done pulse, either the next cycle (single-cycle
  // ops, zero-amount shifts) or after the last shift step. start seen
  // while busy=1 is dropped, not queued.
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] data;
  logic [AW-1:0]    amount;
  logic [WIDTH-1:0] y;
  logic             carry;
  logic             overflow;
  logic             zero;
  logic             busy;
  logic             done;

  modport master (
    output start, op, data, amount,
    input  y, carry, overflow, zero, busy, done
  );

  modport slave (
    input  start, op, data, amount,
    output y, carry, overflow, zero, busy, done
  );

endinterface

// File: rtl/acc_shift_seq.sv
// IDLE/SHIFT sequencer: counts down the remaining shift steps, issues one
// shift enable per cycle and a registered done after the final step.
module acc_shift_seq
  import acc_pkg::*;
#(
  parameter int AW = 3
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          launch_i,
  input  logic [AW-1:0] amount_i,
  output logic          busy_o,
  output logic          shift_en_o,
  output logic          done_o,
  output shift_state_e  state_o
);

  shift_state_e  state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    shift_en_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (launch_i) begin
          state_d = ST_SHIFT;
          cnt_d   = amount_i;
        end
      end
      ST_SHIFT: begin
        shift_en_o = 1'b1;
        cnt_d      = cnt_q - AW'(1);
        if (cnt_q == AW'(1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign busy_o  = (state_q == ST_SHIFT);
  assign done_o  = done_q;
  assign state_o = state_q;

endmodule

// File: rtl/acc_reg.sv
// Parametrised accumulator: single-cycle load/arith/logic ops with flags,
// plus bit-serial shifts sequenced by acc_shift_seq.
module acc_reg
  import acc_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter bit               SATURATE    = 1'b0
) (
  input  logic         clock,
  input  logic         reset,
  acc_reg_if.slave     bus,
  output shift_state_e dbg_state_o
);

  localparam int AW = $clog2(WIDTH);

  logic [WIDTH-1:0] y_q, y_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             op_done_q, op_done_d;
  logic             dir_q, dir_d;
  logic             busy, shift_en, shift_done;
  logic             accept, launch;
  logic [WIDTH:0]   sum, diff;

  assign accept = bus.start & ~busy;
  assign launch = accept & is_shift(bus.op) & (bus.amount != '0);
  assign sum    = {1'b0, y_q} + {1'b0, bus.data};
  assign diff   = {1'b0, y_q} - {1'b0, bus.data};

  acc_shift_seq #(.AW(AW)) u_seq (
    .clk_i      (clock),
    .rst_ni     (reset),
    .launch_i   (launch),
    .amount_i   (bus.amount),
    .busy_o     (busy),
    .shift_en_o (shift_en),
    .done_o     (shift_done),
    .state_o    (dbg_state_o)
  );

  // accept can never coincide with shift_en because busy gates it
  always_comb begin
    y_d       = y_q;
    carry_d   = carry_q;
    ovf_d     = ovf_q;
    op_done_d = 1'b0;
    dir_d     = dir_q;
    if (shift_en) begin
      if (dir_q) begin
        y_d     = y_q >> 1;
        carry_d = y_q[0];
      end else begin
        y_d     = y_q << 1;
        carry_d = y_q[WIDTH-1];
      end
    end else if (accept) begin
      op_done_d = ~launch;
      case (bus.op)
        OP_LOAD: begin
          y_d     = bus.data;
          carry_d = 1'b0;
          ovf_d   = 1'b0;
        end
        OP_ADD: begin
          y_d     = sum[WIDTH-1:0];
          carry_d = sum[WIDTH];
          ovf_d   = (y_q[WIDTH-1] == bus.data[WIDTH-1]) &&
                    (sum[WIDTH-1] != y_q[WIDTH-1]);
          if (SATURATE && sum[WIDTH]) y_d = '1;
        end
        OP_SUB: begin
          y_d     = diff[WIDTH-1:0];
          carry_d = diff[WIDTH];
          ovf_d   = (y_q[WIDTH-1] != bus.data[WIDTH-1]) &&
                    (diff[WIDTH-1] != y_q[WIDTH-1]);
          if (SATURATE && diff[WIDTH]) y_d = '0;
        end
        OP_AND: begin
          y_d     = y_q & bus.data;
          carry_d = 1'b0;
          ovf_d   = 1'b0;
        end
        OP_OR: begin
          y_d     = y_q | bus.data;
          carry_d = 1'b0;
          ovf_d   = 1'b0;
        end
        OP_SHL, OP_SHR: begin
          ovf_d = 1'b0;
          dir_d = (bus.op == OP_SHR);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      y_q       <= RESET_VALUE;
      carry_q   <= 1'b0;
      ovf_q     <= 1'b0;
      op_done_q <= 1'b0;
      dir_q     <= 1'b0;
    end else begin
      y_q       <= y_d;
      carry_q   <= carry_d;
      ovf_q     <= ovf_d;
      op_done_q <= op_done_d;
      dir_q     <= dir_d;
    end
  end

  assign bus.y        = y_q;
  assign bus.carry    = carry_q;
  assign bus.overflow = ovf_q;
  assign bus.zero     = (y_q == '0);
  assign bus.busy     = busy;
  assign bus.done     = op_done_q | shift_done;

endmodule

// File: tb/tb_acc_reg.sv
// Bench for acc_reg: one plain and one saturating instance share stimulus;
// completions are checked against per-instance expected queues.
module tb_acc_reg;
  import acc_pkg::*;

  localparam int W = 8;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  acc_reg_if #(.WIDTH(W)) bus ();
  acc_reg_if #(.WIDTH(W)) sat_bus ();

  assign sat_bus.start  = bus.start;
  assign sat_bus.op     = bus.op;
  assign sat_bus.data   = bus.data;
  assign sat_bus.amount = bus.amount;

  shift_state_e dbg_state, sat_dbg_state;

  acc_reg #(.WIDTH(W), .RESET_VALUE(8'h00), .SATURATE(1'b0)) u_dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  acc_reg #(.WIDTH(W), .RESET_VALUE(8'h00), .SATURATE(1'b1)) u_sat (
    .clock       (clock),
    .reset       (reset),
    .bus         (sat_bus),
    .dbg_state_o (sat_dbg_state)
  );

  int tests = 0;
  int fails = 0;

  // entries are {y, carry, overflow}
  logic [W+1:0] exp_q[$];
  logic [W+1:0] sat_q[$];
  logic [W+1:0] e_main, e_sat;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_done(input logic [W-1:0] y, input logic c, input logic o,
                             input logic [W-1:0] sy, input logic sc, input logic so);
    exp_q.push_back({y, c, o});
    sat_q.push_back({sy, sc, so});
  endtask

  // called just after a negedge; returns at the negedge after the accept edge
  task automatic issue(input logic [2:0] op, input logic [W-1:0] d, input logic [2:0] amt);
    bus.start  = 1'b1;
    bus.op     = op;
    bus.data   = d;
    bus.amount = amt;
    @(negedge clock);
    bus.start  = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 40) begin
      @(negedge clock);
      n++;
    end
    check("idle_timeout", bus.busy, 1'b0);
  endtask

  always @(negedge clock) begin
    if (reset && bus.done) begin
      if (exp_q.size() == 0) check("unexpected_done", 1'b1, 1'b0);
      else begin
        e_main = exp_q.pop_front();
        check("done_y", bus.y, e_main[W+1:2]);
        check("done_carry", bus.carry, e_main[1]);
        check("done_ovf", bus.overflow, e_main[0]);
        check("done_zero", bus.zero, e_main[W+1:2] == '0);
      end
    end
    if (reset && sat_bus.done) begin
      if (sat_q.size() == 0) check("sat_unexpected_done", 1'b1, 1'b0);
      else begin
        e_sat = sat_q.pop_front();
        check("sat_done_y", sat_bus.y, e_sat[W+1:2]);
        check("sat_done_carry", sat_bus.carry, e_sat[1]);
        check("sat_done_ovf", sat_bus.overflow, e_sat[0]);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.start  = 1'b0;
    bus.op     = OP_NOP;
    bus.data   = '0;
    bus.amount = '0;
    reset      = 1'b0;
    @(negedge clock);
    check("rst_y", bus.y, 8'h00);
    check("rst_zero", bus.zero, 1'b1);
    check("rst_carry", bus.carry, 1'b0);
    check("rst_ovf", bus.overflow, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_sat_y", sat_bus.y, 8'h00);
    reset = 1'b1;
    @(negedge clock);

    // carry-out, saturation, flag hold on NOP
    expect_done(8'hF0, 0, 0, 8'hF0, 0, 0); issue(OP_LOAD, 8'hF0, 0);
    expect_done(8'h10, 1, 0, 8'hFF, 1, 0); issue(OP_ADD, 8'h20, 0);
    expect_done(8'h10, 1, 0, 8'hFF, 1, 0); issue(OP_NOP, 8'h00, 0);
    // signed overflow and borrow
    expect_done(8'h7F, 0, 0, 8'h7F, 0, 0); issue(OP_LOAD, 8'h7F, 0);
    expect_done(8'h80, 0, 1, 8'h80, 0, 1); issue(OP_ADD, 8'h01, 0);
    expect_done(8'hFF, 1, 0, 8'h00, 1, 0); issue(OP_SUB, 8'h81, 0);
    // logic ops and a non-borrowing subtract
    expect_done(8'h3C, 0, 0, 8'h3C, 0, 0); issue(OP_LOAD, 8'h3C, 0);
    expect_done(8'h0C, 0, 0, 8'h0C, 0, 0); issue(OP_AND, 8'h0F, 0);
    expect_done(8'hAC, 0, 0, 8'hAC, 0, 0); issue(OP_OR, 8'hA0, 0);
    expect_done(8'hA0, 0, 0, 8'hA0, 0, 0); issue(OP_SUB, 8'h0C, 0);

    // SHL by 3 with an ignored ADD request while busy
    expect_done(8'hA1, 0, 0, 8'hA1, 0, 0); issue(OP_LOAD, 8'hA1, 0);
    expect_done(8'h08, 1, 0, 8'h08, 1, 0);
    bus.start = 1'b1; bus.op = OP_SHL; bus.data = 8'h00; bus.amount = 3'd3;
    @(negedge clock);
    check("shl_k_busy", bus.busy, 1'b1);
    check("shl_k_y", bus.y, 8'hA1);
    check("shl_k_done", bus.done, 1'b0);
    bus.op = OP_ADD; bus.data = 8'h01;
    @(negedge clock);
    bus.start = 1'b0;
    check("shl_k1_y", bus.y, 8'h42);
    check("shl_k1_carry", bus.carry, 1'b1);
    check("shl_k1_busy", bus.busy, 1'b1);
    @(negedge clock);
    check("shl_k2_y", bus.y, 8'h84);
    check("shl_k2_carry", bus.carry, 1'b0);
    @(negedge clock);
    check("shl_k3_y", bus.y, 8'h08);
    check("shl_k3_busy", bus.busy, 1'b0);
    check("shl_k3_done", bus.done, 1'b1);
    @(negedge clock);

    // SHR by 7 aborted by reset two edges in
    expect_done(8'hFF, 0, 0, 8'hFF, 0, 0); issue(OP_LOAD, 8'hFF, 0);
    bus.start = 1'b1; bus.op = OP_SHR; bus.data = 8'h00; bus.amount = 3'd7;
    @(negedge clock);
    bus.start = 1'b0;
    @(negedge clock);
    check("shr_k1_y", bus.y, 8'h7F);
    check("shr_k1_busy", bus.busy, 1'b1);
    reset = 1'b0;
    @(negedge clock);
    check("abort_y", bus.y, 8'h00);
    check("abort_busy", bus.busy, 1'b0);
    check("abort_carry", bus.carry, 1'b0);
    check("abort_done", bus.done, 1'b0);
    check("abort_state", dbg_state, ST_IDLE);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      check("abort_no_done", bus.done, 1'b0);
      check("abort_sat_no_done", sat_bus.done, 1'b0);
    end

    // zero-amount shift keeps y and carry
    expect_done(8'hD5, 0, 0, 8'hD5, 0, 0); issue(OP_LOAD, 8'hD5, 0);
    expect_done(8'h55, 1, 1, 8'hFF, 1, 1); issue(OP_ADD, 8'h80, 0);
    expect_done(8'h55, 1, 0, 8'hFF, 1, 0); issue(OP_SHL, 8'h00, 0);
    check("shl0_busy", bus.busy, 1'b0);
    check("shl0_done", bus.done, 1'b1);
    @(negedge clock);
    check("shl0_busy_after", bus.busy, 1'b0);

    // back-to-back: second start presented in the done cycle of the first
    expect_done(8'h15, 0, 0, 8'h3F, 1, 0); issue(OP_SHR, 8'h00, 2);
    check("b2b_busy", bus.busy, 1'b1);
    wait_idle();
    expect_done(8'h2A, 0, 0, 8'h7E, 0, 0); issue(OP_SHL, 8'h00, 1);
    check("b2b2_busy", bus.busy, 1'b1);
    wait_idle();

    repeat (3) @(negedge clock);
    check("exp_q_empty", exp_q.size(), 0);
    check("sat_q_empty", sat_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
